// File: rtl/seq_repeat_checker_if.sv
// Bundle between the a/b/c stimulus driver (master) and the sequence checker (slave).
// Latency: n/a (wires only); the checker registers every output it drives here.
// Backpressure: none; the checker samples a/b/c every cycle and cannot stall the driver.
// Optional macro SEQ_CHK_FAIL_LOG_EN adds first_fail_code / first_fail_rep.
interface seq_repeat_checker_if #(
  parameter int MAX_REP = 2,
  parameter int CNT_W   = 8
);
  localparam int REP_W = $clog2(MAX_REP + 1);

  logic             a;
  logic             b;
  logic             c;
  logic             clr_cnt;
  logic             busy;
  logic [REP_W-1:0] rep_cnt;
  logic             pass;
  logic             fail;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
`ifdef SEQ_CHK_FAIL_LOG_EN
  logic [1:0]       first_fail_code;
  logic [REP_W-1:0] first_fail_rep;

  modport master (
    output a, b, c, clr_cnt,
    input  busy, rep_cnt, pass, fail, pass_cnt, fail_cnt,
    input  first_fail_code, first_fail_rep
  );
  modport slave (
    input  a, b, c, clr_cnt,
    output busy, rep_cnt, pass, fail, pass_cnt, fail_cnt,
    output first_fail_code, first_fail_rep
  );
`else
  modport master (
    output a, b, c, clr_cnt,
    input  busy, rep_cnt, pass, fail, pass_cnt, fail_cnt
  );
  modport slave (
    input  a, b, c, clr_cnt,
    output busy, rep_cnt, pass, fail, pass_cnt, fail_cnt
  );
`endif
endinterface

// File: rtl/seq_repeat_checker.sv
// Hardware checker for "a ##1 b[*0:MAX_REP] ##1 c"; single attempt in flight, registered pass/fail pulses and saturating counters.
// Latency: pass/fail pulse and counter update appear one cycle after the deciding sample.
// Backpressure: none; inputs are sampled every posedge. Optional macro SEQ_CHK_FAIL_LOG_EN adds a sticky first-fail log.
module seq_repeat_checker #(
  parameter int MAX_REP = 2,
  parameter int CNT_W   = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_repeat_checker_if.slave bus
);
  localparam int REP_W = $clog2(MAX_REP + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(MAX_REP);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] CODE_GAP  = 2'b01;
  localparam logic [1:0] CODE_MANY = 2'b10;

  logic [0:0]       state_q, state_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

  logic in_run;
  logic hit_pass;
  logic hit_gap;
  logic hit_many;
  logic resolve;

  // Classify the current sample; c has priority over b, and b/c are ignored in IDLE.
  always_comb begin
    in_run   = (state_q == ST_RUN);
    hit_pass = in_run && bus.c;
    hit_gap  = in_run && !bus.c && !bus.b;
    hit_many = in_run && !bus.c && bus.b && (rep_q == REP_MAX);
    resolve  = hit_pass || hit_gap || hit_many;
  end

  // Next state: a re-arms on a resolving edge, otherwise a is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    if (!in_run) begin
      state_d = bus.a ? ST_RUN : ST_IDLE;
      rep_d   = '0;
    end else if (resolve) begin
      state_d = bus.a ? ST_RUN : ST_IDLE;
      rep_d   = '0;
    end else begin
      state_d = ST_RUN;
      rep_d   = rep_q + REP_ONE;
    end
  end

  // Pulse and counter next values; clear wins over a same-cycle increment, counts saturate.
  always_comb begin
    pass_d     = hit_pass;
    fail_d     = hit_gap || hit_many;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (bus.clr_cnt) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end else begin
      if (pass_d && !(&pass_cnt_q)) pass_cnt_d = pass_cnt_q + CNT_ONE;
      if (fail_d && !(&fail_cnt_q)) fail_cnt_d = fail_cnt_q + CNT_ONE;
    end
  end

  // State, pulse and counter registers; reset discards any attempt in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rep_q      <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rep_q      <= rep_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign bus.busy     = (state_q == ST_RUN);
  assign bus.rep_cnt  = rep_q;
  assign bus.pass     = pass_q;
  assign bus.fail     = fail_q;
  assign bus.pass_cnt = pass_cnt_q;
  assign bus.fail_cnt = fail_cnt_q;

`ifdef SEQ_CHK_FAIL_LOG_EN
  logic [1:0]       ff_code_q, ff_code_d;
  logic [REP_W-1:0] ff_rep_q, ff_rep_d;

  // A zero code means nothing logged yet; only the first fail after reset/clear is captured.
  always_comb begin
    ff_code_d = ff_code_q;
    ff_rep_d  = ff_rep_q;
    if (bus.clr_cnt) begin
      ff_code_d = '0;
      ff_rep_d  = '0;
    end else if (ff_code_q == 2'b00 && (hit_gap || hit_many)) begin
      ff_code_d = hit_gap ? CODE_GAP : CODE_MANY;
      ff_rep_d  = rep_q;
    end
  end

  // Sticky first-fail log registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_code_q <= '0;
      ff_rep_q  <= '0;
    end else begin
      ff_code_q <= ff_code_d;
      ff_rep_q  <= ff_rep_d;
    end
  end

  assign bus.first_fail_code = ff_code_q;
  assign bus.first_fail_rep  = ff_rep_q;
`endif
endmodule

// File: tb/tb_seq_repeat_checker.sv
// Directed bench for seq_repeat_checker with MAX_REP=2, CNT_W=8.
// Table of per-cycle vectors plus hand sequences for reset mid-attempt, saturation and clear.
module tb_seq_repeat_checker;
  localparam int MAX_REP = 2;
  localparam int CNT_W   = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  seq_repeat_checker_if #(.MAX_REP(MAX_REP), .CNT_W(CNT_W)) bus ();

  seq_repeat_checker #(.MAX_REP(MAX_REP), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic a, b, c, clr;
    int   busy, rep, pass, fail, pcnt, fcnt, ffc, ffr;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic a, input logic b, input logic c, input logic clr);
    bus.a = a; bus.b = b; bus.c = c; bus.clr_cnt = clr;
  endtask

  // Apply inputs, let one posedge sample them, then look 1 time unit after the edge.
  task automatic step(input logic a, input logic b, input logic c, input logic clr);
    drive(a, b, c, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int busy, input int rep, input int pass,
                           input int fail, input int pcnt, input int fcnt, input int ffc, input int ffr);
    check({tag, ".busy"}, int'(bus.busy), busy);
    check({tag, ".rep_cnt"}, int'(bus.rep_cnt), rep);
    check({tag, ".pass"}, int'(bus.pass), pass);
    check({tag, ".fail"}, int'(bus.fail), fail);
    check({tag, ".pass_cnt"}, int'(bus.pass_cnt), pcnt);
    check({tag, ".fail_cnt"}, int'(bus.fail_cnt), fcnt);
`ifdef SEQ_CHK_FAIL_LOG_EN
    check({tag, ".first_fail_code"}, int'(bus.first_fail_code), ffc);
    check({tag, ".first_fail_rep"}, int'(bus.first_fail_rep), ffr);
`else
    if (ffc < 0 || ffr < 0) $display("note: negative log expectation ignored");
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    //          a  b  c  clr busy rep pass fail pcnt fcnt ffc ffr
    vecs[0]  = '{1, 0, 0, 0,  1,  0,  0,  0,  0,  0,  0,  0}; // a starts
    vecs[1]  = '{0, 1, 0, 0,  1,  1,  0,  0,  0,  0,  0,  0}; // one b
    vecs[2]  = '{0, 0, 1, 0,  0,  0,  1,  0,  1,  0,  0,  0}; // c -> pass
    vecs[3]  = '{0, 0, 0, 0,  0,  0,  0,  0,  1,  0,  0,  0}; // pulse is one cycle
    vecs[4]  = '{1, 0, 0, 0,  1,  0,  0,  0,  1,  0,  0,  0}; // a
    vecs[5]  = '{0, 0, 1, 0,  0,  0,  1,  0,  2,  0,  0,  0}; // zero b then c
    vecs[6]  = '{1, 0, 0, 0,  1,  0,  0,  0,  2,  0,  0,  0};
    vecs[7]  = '{0, 1, 0, 0,  1,  1,  0,  0,  2,  0,  0,  0};
    vecs[8]  = '{0, 1, 0, 0,  1,  2,  0,  0,  2,  0,  0,  0}; // MAX_REP b's
    vecs[9]  = '{0, 0, 1, 0,  0,  0,  1,  0,  3,  0,  0,  0}; // pass at limit
    vecs[10] = '{1, 0, 0, 0,  1,  0,  0,  0,  3,  0,  0,  0};
    vecs[11] = '{0, 1, 0, 0,  1,  1,  0,  0,  3,  0,  0,  0};
    vecs[12] = '{0, 1, 0, 0,  1,  2,  0,  0,  3,  0,  0,  0};
    vecs[13] = '{0, 1, 0, 0,  0,  0,  0,  1,  3,  1,  2,  2}; // third b -> too many
    vecs[14] = '{0, 0, 0, 0,  0,  0,  0,  0,  3,  1,  2,  2};
    vecs[15] = '{1, 0, 0, 0,  1,  0,  0,  0,  3,  1,  2,  2};
    vecs[16] = '{0, 0, 0, 0,  0,  0,  0,  1,  3,  2,  2,  2}; // gap; log stays sticky
    vecs[17] = '{1, 0, 0, 0,  1,  0,  0,  0,  3,  2,  2,  2};
    vecs[18] = '{1, 0, 1, 0,  1,  0,  1,  0,  4,  2,  2,  2}; // pass and re-arm
    vecs[19] = '{0, 1, 1, 0,  0,  0,  1,  0,  5,  2,  2,  2}; // c beats b
    vecs[20] = '{0, 1, 1, 0,  0,  0,  0,  0,  5,  2,  2,  2}; // b/c ignored in IDLE
    vecs[21] = '{0, 0, 0, 1,  0,  0,  0,  0,  0,  0,  0,  0}; // clear
    vecs[22] = '{1, 0, 0, 0,  1,  0,  0,  0,  0,  0,  0,  0};
    vecs[23] = '{1, 1, 0, 0,  1,  1,  0,  0,  0,  0,  0,  0}; // a ignored mid-attempt
    vecs[24] = '{0, 0, 0, 0,  0,  0,  0,  1,  0,  1,  1,  1}; // gap at rep 1
    vecs[25] = '{0, 0, 0, 0,  0,  0,  0,  0,  0,  1,  1,  1};

    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 26; i++) begin
      step(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].busy, vecs[i].rep, vecs[i].pass,
                vecs[i].fail, vecs[i].pcnt, vecs[i].fcnt, vecs[i].ffc, vecs[i].ffr);
      check($sformatf("vec%0d.pass_and_fail", i), int'(bus.pass && bus.fail), 0);
    end

    // Reset mid-attempt with rep_cnt=1; c is pending so a lost reset would show a pass.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    check("mid.busy_before", int'(bus.busy), 1);
    check("mid.rep_before", int'(bus.rep_cnt), 1);
    check("mid.fcnt_before", int'(bus.fail_cnt), 1);
    drive(0, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("mid_async", 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("mid_held", 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0);
    check_all("mid_after", 0, 0, 0, 0, 0, 0, 0, 0);

    // Saturation: back-to-back passes with re-arm, one pass per cycle.
    step(1, 0, 0, 0);
    for (int n = 1; n <= 256; n++) begin
      step(1, 0, 1, 0);
      if (n == 254 || n == 255 || n == 256) begin
        check($sformatf("sat%0d.pass_cnt", n), int'(bus.pass_cnt), (n > 255) ? 255 : n);
        check($sformatf("sat%0d.pass", n), int'(bus.pass), 1);
        check($sformatf("sat%0d.busy", n), int'(bus.busy), 1);
      end
    end
    check("sat.fail_cnt", int'(bus.fail_cnt), 0);

    // Clear together with a passing sample: pulse still fires, counters read 0.
    step(0, 0, 1, 1);
    check_all("clr_pass", 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_all("clr_idle", 0, 0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got %0d failures so far", n_fail);
    $fatal(1, "timeout");
  end
endmodule
